// File: rtl/router_pkg.sv
// Shared types and default sizing for the 1x3 router ingress control path.
package router_pkg;

    localparam int NUM_DEST_DEF = 3;
    localparam int ADDR_W_DEF   = 2;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        WAIT_TILL_EMPTY    = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

endpackage

// File: rtl/router_fsm.sv
// Ingress control FSM: decodes header address, sequences register-block loads and parity check.
// Latency: one state per clock; outputs are Moore, decoded from the registered state only.
// Backpressure: busy holds the source byte in every state except DECODE_ADDRESS and LOAD_DATA.
module router_fsm
    import router_pkg::*;
#(
    parameter int NUM_DEST = NUM_DEST_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                pkt_valid,
    input  logic [ADDR_W-1:0]   data_in,
    input  logic                fifo_full,
    input  logic [NUM_DEST-1:0] fifo_empty,
    input  logic [NUM_DEST-1:0] soft_reset,
    input  logic                parity_done,
    input  logic                low_pkt_valid,
    output logic                detect_add,
    output logic                lfd_state,
    output logic                ld_state,
    output logic                laf_state,
    output logic                full_state,
    output logic                rst_int_reg,
    output logic                write_enb_reg,
    output logic                busy,
    output logic [ADDR_W-1:0]   dest_sel,
    output logic [2:0]          state_o
);

    localparam int                ADDR_SPACE = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   NUM_DEST_W = (ADDR_W + 1)'(NUM_DEST);

    state_t                  state;
    state_t                  state_nxt;
    logic                    addr_ok;
    logic [ADDR_SPACE-1:0]   empty_pad;
    logic [ADDR_SPACE-1:0]   srst_pad;

    // Pad per-port flags to the full address space so out-of-range indices read as 0.
    always_comb begin
        empty_pad                 = '0;
        srst_pad                  = '0;
        empty_pad[NUM_DEST-1:0]   = fifo_empty;
        srst_pad[NUM_DEST-1:0]    = soft_reset;
    end

    assign addr_ok = pkt_valid && ({1'b0, data_in} < NUM_DEST_W);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= DECODE_ADDRESS;
            dest_sel <= '0;
        end else begin
            state <= state_nxt;
            if (state == DECODE_ADDRESS && addr_ok) begin
                dest_sel <= data_in;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DECODE_ADDRESS: begin
                if (addr_ok) begin
                    state_nxt = empty_pad[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (empty_pad[dest_sel]) begin
                    state_nxt = LOAD_FIRST_DATA;
                end
            end
            LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full) begin
                    state_nxt = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    state_nxt = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) begin
                    state_nxt = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    state_nxt = DECODE_ADDRESS;
                end else if (low_pkt_valid) begin
                    state_nxt = LOAD_PARITY;
                end else begin
                    state_nxt = LOAD_DATA;
                end
            end
            LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: state_nxt = DECODE_ADDRESS;
        endcase

        // A read-timeout on the selected port abandons the packet from any active state.
        if (state != DECODE_ADDRESS && srst_pad[dest_sel]) begin
            state_nxt = DECODE_ADDRESS;
        end
    end

    always_comb begin
        detect_add    = (state == DECODE_ADDRESS);
        lfd_state     = (state == LOAD_FIRST_DATA);
        ld_state      = (state == LOAD_DATA);
        laf_state     = (state == LOAD_AFTER_FULL);
        full_state    = (state == FIFO_FULL_STATE);
        rst_int_reg   = (state == CHECK_PARITY_ERROR);
        write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                        (state == LOAD_AFTER_FULL);
        busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
        state_o       = state;
    end

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed packet scenarios plus randomized traffic against a behavioural model.
module tb_router_fsm;

    localparam int ND = 3;

    localparam int S_DEC  = 0;
    localparam int S_LFD  = 1;
    localparam int S_LD   = 2;
    localparam int S_WTE  = 3;
    localparam int S_FULL = 4;
    localparam int S_LAF  = 5;
    localparam int S_LP   = 6;
    localparam int S_CPE  = 7;

    logic          clock = 1'b0;
    logic          resetn;
    logic          pkt_valid;
    logic [1:0]    data_in;
    logic          fifo_full;
    logic [ND-1:0] fifo_empty;
    logic [ND-1:0] soft_reset;
    logic          parity_done;
    logic          low_pkt_valid;
    logic          detect_add, lfd_state, ld_state, laf_state, full_state;
    logic          rst_int_reg, write_enb_reg, busy;
    logic [1:0]    dest_sel;
    logic [2:0]    state_o;

    int n_checks = 0;
    int n_fail   = 0;
    int m_state  = S_DEC;
    int m_dest   = 0;
    int cnt_we, cnt_rst, cnt_lfd, cnt_full, cnt_busy;

    router_fsm dut (
        .clock        (clock),
        .resetn       (resetn),
        .pkt_valid    (pkt_valid),
        .data_in      (data_in),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .soft_reset   (soft_reset),
        .parity_done  (parity_done),
        .low_pkt_valid(low_pkt_valid),
        .detect_add   (detect_add),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .full_state   (full_state),
        .rst_int_reg  (rst_int_reg),
        .write_enb_reg(write_enb_reg),
        .busy         (busy),
        .dest_sel     (dest_sel),
        .state_o      (state_o)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [12:0] obs_vec();
        return {detect_add, lfd_state, ld_state, laf_state, full_state,
                rst_int_reg, write_enb_reg, busy, dest_sel, state_o};
    endfunction

    // Expected outputs derived directly from which phase the packet is in.
    function automatic logic [12:0] exp_vec(input int s, input int d);
        logic det, lfd, ld, laf, ful, rst, we, bsy;
        det = (s == S_DEC);
        lfd = (s == S_LFD);
        ld  = (s == S_LD);
        laf = (s == S_LAF);
        ful = (s == S_FULL);
        rst = (s == S_CPE);
        we  = (s == S_LD) || (s == S_LP) || (s == S_LAF);
        bsy = !((s == S_DEC) || (s == S_LD));
        return {det, lfd, ld, laf, ful, rst, we, bsy, 2'(d), 3'(s)};
    endfunction

    task automatic model_update();
        int d;
        int n;
        d = int'(data_in);
        n = m_state;
        if (m_state != S_DEC && m_dest < ND && soft_reset[m_dest]) begin
            n = S_DEC;
        end else begin
            case (m_state)
                S_DEC:  if (pkt_valid && d < ND) begin
                            n = fifo_empty[d] ? S_LFD : S_WTE;
                        end
                S_WTE:  if (fifo_empty[m_dest]) n = S_LFD;
                S_LFD:  n = S_LD;
                S_LD:   if (fifo_full) n = S_FULL; else if (!pkt_valid) n = S_LP;
                S_FULL: if (!fifo_full) n = S_LAF;
                S_LAF:  n = parity_done ? S_DEC : (low_pkt_valid ? S_LP : S_LD);
                S_LP:   n = S_CPE;
                default: n = fifo_full ? S_FULL : S_DEC;
            endcase
        end
        if (m_state == S_DEC && pkt_valid && d < ND) m_dest = d;
        m_state = n;
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        #1;
        chk("outs", 32'(obs_vec()), 32'(exp_vec(m_state, m_dest)));
        if (write_enb_reg) cnt_we++;
        if (rst_int_reg)   cnt_rst++;
        if (lfd_state)     cnt_lfd++;
        if (full_state)    cnt_full++;
        if (busy)          cnt_busy++;
    endtask

    task automatic clr_counts();
        cnt_we = 0; cnt_rst = 0; cnt_lfd = 0; cnt_full = 0; cnt_busy = 0;
    endtask

    task automatic idle();
        pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0; fifo_empty = 3'b111;
        soft_reset = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 4; i++) step();
    endtask

    initial begin
        idle();
        resetn = 1'b0;
        #12;
        chk("reset_outs", 32'(obs_vec()), 32'(exp_vec(S_DEC, 0)));
        chk("reset_busy", 32'(busy), 32'd0);
        resetn = 1'b1;

        // Header to port 1 with all FIFOs empty, three payload bytes, then parity.
        clr_counts();
        pkt_valid = 1'b1; data_in = 2'd1;
        step();
        chk("hdr1_dest", 32'(dest_sel), 32'd1);
        chk("hdr1_lfd", 32'(state_o), 32'd1);
        step();
        step();
        step();
        pkt_valid = 1'b0;
        step();
        step();
        step();
        chk("pkt1_back_dec", 32'(state_o), 32'd0);
        chk("pkt1_lfd_cnt", 32'(cnt_lfd), 32'd1);
        chk("pkt1_busy_cnt", 32'(cnt_busy), 32'd3);
        chk("pkt1_we_cnt", 32'(cnt_we), 32'd4);
        chk("pkt1_rst_cnt", 32'(cnt_rst), 32'd1);

        // FIFO full on the second payload byte, held three cycles.
        clr_counts();
        pkt_valid = 1'b1; data_in = 2'd0;
        step();
        step();
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_we", 32'(write_enb_reg), 32'd0);
            chk("full_busy", 32'(busy), 32'd1);
        end
        chk("full_cnt", 32'(cnt_full), 32'd3);
        fifo_full = 1'b0;
        step();
        chk("laf", 32'(state_o), 32'd5);
        step();
        chk("laf_to_ld", 32'(state_o), 32'd2);
        drain();

        // Port 2 not empty for five cycles, then header to invalid port 3.
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b011;
        step();
        for (int i = 0; i < 4; i++) step();
        chk("wte_state", 32'(state_o), 32'd3);
        chk("wte_busy", 32'(busy), 32'd1);
        fifo_empty = 3'b111;
        step();
        chk("wte_to_lfd", 32'(state_o), 32'd1);
        drain();
        pkt_valid = 1'b1; data_in = 2'd3;
        for (int i = 0; i < 3; i++) step();
        chk("bad_addr_state", 32'(state_o), 32'd0);
        chk("bad_addr_dest", 32'(dest_sel), 32'd2);

        // Soft reset on selected port aborts; on another port is ignored.
        data_in = 2'd0;
        step();
        step();
        soft_reset = 3'b001;
        step();
        chk("srst_sel", 32'(state_o), 32'd0);
        drain();
        pkt_valid = 1'b1; data_in = 2'd0;
        step();
        step();
        soft_reset = 3'b010;
        step();
        chk("srst_other", 32'(state_o), 32'd2);
        drain();

        // Asynchronous reset while in LOAD_DATA.
        pkt_valid = 1'b1; data_in = 2'd1;
        step();
        step();
        #3;
        resetn = 1'b0;
        #1;
        chk("arst_outs", 32'(obs_vec()), 32'(exp_vec(S_DEC, 0)));
        chk("arst_we", 32'(write_enb_reg), 32'd0);
        m_state = S_DEC;
        m_dest  = 0;
        idle();
        #2;
        resetn = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            pkt_valid     = ($urandom_range(3) != 0);
            data_in       = 2'($urandom_range(3));
            fifo_full     = ($urandom_range(3) == 0);
            fifo_empty    = 3'($urandom_range(7));
            soft_reset    = ($urandom_range(15) == 0) ? 3'(1 << $urandom_range(2)) : 3'b000;
            parity_done   = ($urandom_range(3) == 0);
            low_pkt_valid = ($urandom_range(1) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
